// File: rtl/dec_ascii_pkg.sv
// Shared types and constants for the binary-to-decimal ASCII serializer.
// The TERM state exists only when DEC_ASCII_NEWLINE_EN is defined.
package dec_ascii_pkg;

    localparam int         MAX_DIGITS = 10;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        EMIT
`ifdef DEC_ASCII_NEWLINE_EN
        , TERM
`endif
    } state_t;

    // Position of the most significant non-zero digit; 0 when all digits are zero.
    function automatic logic [3:0] msd_index(input logic [4*MAX_DIGITS-1:0] bcd);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dec_ascii_dabble_step.sv
// One combinational double-dabble step: add 3 to every digit >= 5,
// then shift the whole BCD vector left by one, inserting shift_bit.
module dec_ascii_dabble_step
    import dec_ascii_pkg::*;
(
    input  logic [4*MAX_DIGITS-1:0] bcd_in,
    input  logic                    shift_bit,
    output logic [4*MAX_DIGITS-1:0] bcd_out
);

    logic [4*MAX_DIGITS-1:0] adjusted;
    bcd_digit_t              digit;

    always_comb begin
        adjusted = '0;
        digit    = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            digit = bcd_in[4*i +: 4];
            adjusted[4*i +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
        end
        bcd_out = (adjusted << 1) | {{(4*MAX_DIGITS-1){1'b0}}, shift_bit};
    end

endmodule

// File: rtl/dec_ascii_serializer.sv
// Converts each accepted unsigned value to a decimal ASCII character stream, MSD first.
// Define DEC_ASCII_NEWLINE_EN to append a 0x0A terminator carrying out_last.
module dec_ascii_serializer
    import dec_ascii_pkg::*;
#(
    parameter int IN_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [IN_WIDTH-1:0] in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [7:0]          out_data,
    output logic                out_last,
    input  logic                out_ready
);

    localparam int CNT_W = $clog2(IN_WIDTH + 1);

    state_t                  state;
    state_t                  state_next;
    logic [IN_WIDTH-1:0]     data_reg;
    logic [4*MAX_DIGITS-1:0] bcd_reg;
    logic [4*MAX_DIGITS-1:0] bcd_step;
    logic [CNT_W-1:0]        bit_cnt;
    logic [3:0]              digit_idx;
    logic                    convert_done;
    bcd_digit_t              cur_digit;

    assign convert_done = (bit_cnt == CNT_W'(IN_WIDTH));

    dec_ascii_dabble_step u_step (
        .bcd_in    (bcd_reg),
        .shift_bit (data_reg[IN_WIDTH-1]),
        .bcd_out   (bcd_step)
    );

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (digit_idx == 4'(i)) cur_digit = bcd_reg[4*i +: 4];
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        out_last   = 1'b0;
        case (state)
            IDLE: begin
                // Held low while reset is asserted so upstream never sees a ready in reset.
                in_ready = rst_n;
                if (in_valid) state_next = CONVERT;
            end
            CONVERT: begin
                if (convert_done) state_next = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_data  = ASCII_ZERO + {4'b0000, cur_digit};
`ifdef DEC_ASCII_NEWLINE_EN
                if (out_ready && digit_idx == 4'd0) state_next = TERM;
`else
                out_last  = (digit_idx == 4'd0);
                if (out_ready && digit_idx == 4'd0) state_next = IDLE;
`endif
            end
`ifdef DEC_ASCII_NEWLINE_EN
            TERM: begin
                out_valid = 1'b1;
                out_data  = ASCII_LF;
                out_last  = 1'b1;
                if (out_ready) state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            data_reg  <= '0;
            bcd_reg   <= '0;
            bit_cnt   <= '0;
            digit_idx <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_reg <= in_data;
                        bcd_reg  <= '0;
                        bit_cnt  <= '0;
                    end
                end
                CONVERT: begin
                    // The cycle after the last step latches the emit start position.
                    if (!convert_done) begin
                        data_reg <= data_reg << 1;
                        bcd_reg  <= bcd_step;
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                    end else begin
                        digit_idx <= msd_index(bcd_reg);
                    end
                end
                EMIT: begin
                    if (out_ready && digit_idx != 4'd0) digit_idx <= digit_idx - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_ascii_serializer.sv
// Scoreboard bench for dec_ascii_serializer: expected characters are queued on send
// and compared as the DUT hands them over.
module tb_dec_ascii_serializer;

    localparam int W       = 32;
    localparam int LATENCY = W + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic         out_last;
    logic         out_ready;

    logic [8:0] exp_q[$];
    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dec_ascii_serializer #(.IN_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    function automatic void push_expected(input logic [31:0] v);
        logic [7:0]  d[$];
        logic [31:0] t;
        t = v;
        do begin
            d.push_front(8'h30 + 8'(t % 10));
            t = t / 10;
        end while (t != 0);
        for (int i = 0; i < d.size(); i++) begin
`ifdef DEC_ASCII_NEWLINE_EN
            exp_q.push_back({1'b0, d[i]});
`else
            exp_q.push_back({(i == d.size() - 1), d[i]});
`endif
        end
`ifdef DEC_ASCII_NEWLINE_EN
        exp_q.push_back({1'b1, 8'h0A});
`endif
    endfunction

    task automatic send(input logic [31:0] v);
        int n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = v;
        push_expected(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom();
    endtask

    // Consumes characters until the queue empties or max_chars have been taken.
    task automatic drain(input int stall_pct, input bit check_latency, input int max_chars);
        int         cyc = 0;
        int         first = -1;
        int         taken = 0;
        bit         held_valid = 0;
        logic [8:0] held = '0;
        logic [8:0] exp;
        while (exp_q.size() > 0 && taken < max_chars && cyc < 2000) begin
            @(negedge clk);
            if (held_valid) begin
                vectors++;
                if ({out_valid, out_last, out_data} !== {1'b1, held}) begin
                    miscompares++;
                    $display("FAIL stall_stable: got v=%b last=%b data=%h required v=1 last=%b data=%h",
                             out_valid, out_last, out_data, held[8], held[7:0]);
                end
            end
            if (out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ready_during_emit: in_ready=%b required 0", in_ready);
                end
                out_ready = ($urandom_range(99) >= stall_pct);
                if (out_ready) begin
                    exp = exp_q.pop_front();
                    taken++;
                    held_valid = 0;
                    vectors++;
                    if ({out_last, out_data} !== exp) begin
                        miscompares++;
                        $display("FAIL char: got last=%b data=%h required last=%b data=%h",
                                 out_last, out_data, exp[8], exp[7:0]);
                    end
                end else begin
                    held       = {out_last, out_data};
                    held_valid = 1;
                end
            end else begin
                out_ready = $urandom_range(1);
            end
            cyc++;
        end
        if (exp_q.size() > 0 && taken < max_chars) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d chars outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        if (check_latency) begin
            vectors++;
            if (first != LATENCY) begin
                miscompares++;
                $display("FAIL latency: first out_valid after %0d cycles required %0d", first, LATENCY);
            end
        end
    endtask

    task automatic check_idle_after();
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL return_idle: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        vectors++;
        if ({in_ready, out_valid, out_last, out_data} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b valid=%b last=%b data=%h required all 0",
                     in_ready, out_valid, out_last, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_zero();
        send(32'd0);
        drain(0, 1'b1, 100);
        check_idle_after();
    endtask

    task automatic test_fib47();
        send(32'd2971215073);
        drain(0, 1'b1, 100);
        check_idle_after();
    endtask

    task automatic test_max();
        send(32'd4294967295);
        drain(20, 1'b1, 100);
        check_idle_after();
    endtask

    task automatic test_thousand_stall();
        send(32'd1000);
        drain(60, 1'b0, 100);
        check_idle_after();
    endtask

    task automatic test_reset_midstream();
        send(32'd4294967295);
        drain(0, 1'b0, 2);
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, out_last, out_data} !== 11'b0) begin
            miscompares++;
            $display("FAIL midstream_reset: ready=%b valid=%b last=%b data=%h required all 0",
                     in_ready, out_valid, out_last, out_data);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        send(32'd7);
        drain(0, 1'b1, 100);
        check_idle_after();
    endtask

    task automatic test_newline();
        send(32'd42);
        drain(30, 1'b0, 100);
        check_idle_after();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals[6];
        vals = '{32'd9, 32'd10, 32'd99999, 32'd1000000000, 32'd3000000001, 32'd0};
        for (int i = 0; i < 6; i++) begin
            send(vals[i]);
            drain(30, 1'b0, 100);
        end
        for (int i = 0; i < 6; i++) begin
            send($urandom());
            drain(40, 1'b0, 100);
        end
        check_idle_after();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_fib47();
        test_max();
        test_thousand_stall();
        test_reset_midstream();
        test_newline();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dec_ascii_serializer.md
DEC_ASCII_SERIALIZER -- requirements
Module: dec_ascii_serializer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, binary input width; legal range 4..32.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  upstream value valid.
REQ-005 SHALL have port in_data  input  IN_WIDTH  unsigned binary value; the fibonacci out_data stream connects here.
REQ-006 SHALL have port in_ready  output  1  block can accept a value.
REQ-007 SHALL have port out_valid  output  1  ASCII character valid.
REQ-008 SHALL have port out_data  output  8  ASCII character.
REQ-009 SHALL have port out_last  output  1  marks final character of a value.
REQ-010 SHALL have port out_ready  input  1  downstream accepts character.

Function
REQ-011 SHALL convert each accepted value to its unsigned decimal ASCII string, most significant digit first.
REQ-012 SHALL implement FSM states IDLE, CONVERT, EMIT, plus TERM when DEC_ASCII_NEWLINE_EN is defined.
REQ-013 SHALL assert in_ready only in IDLE; a value transfers when in_valid & in_ready on a clock edge.
REQ-014 SHALL on transfer capture in_data, clear the BCD register, and go IDLE -> CONVERT.
REQ-015 SHALL in CONVERT perform exactly one double-dabble step per cycle (add 3 to every BCD digit >= 5, then shift in the next input bit, MSB first), for IN_WIDTH cycles, then go to EMIT.
REQ-016 SHALL hold a BCD register of MAX_DIGITS = 10 four-bit digits, sufficient for any IN_WIDTH <= 32.
REQ-017 SHALL assert first out_valid exactly IN_WIDTH+1 cycles after the accepting edge (33 cycles for IN_WIDTH=32).
REQ-018 SHALL suppress leading zero digits; internal and trailing zeros are emitted.
REQ-019 SHALL emit a single character 0x30 with out_last=1 for input value 0.
REQ-020 SHALL drive out_data = 0x30 + digit for each emitted digit.
REQ-021 SHALL advance to the next character only on out_valid & out_ready; out_data and out_last SHALL stay stable while out_valid & ~out_ready.
REQ-022 SHALL never deassert out_valid in EMIT/TERM before the character is accepted.
REQ-023 SHALL after the handshake of the last character return to IDLE, with in_ready asserted the following cycle; no overlap of consecutive values.
REQ-024 SHALL ignore in_data changes while not in IDLE.

Reset
REQ-025 SHALL on rst_n low, asynchronously and regardless of state, enter IDLE, clear data/BCD registers, and drive out_valid=0, out_last=0, out_data=0, in_ready=0.
REQ-026 SHALL assert in_ready in the first cycle after rst_n deasserts; any value in conversion or emission at reset is discarded with no partial output.

Configuration
REQ-027 SHALL, when macro DEC_ASCII_NEWLINE_EN is defined, emit 0x0A (TERM state) after the last digit, with out_last on 0x0A only and not on the digit.
REQ-028 SHALL, without DEC_ASCII_NEWLINE_EN, omit TERM and assert out_last on the final digit.

Structure
REQ-029 SHALL take from package dec_ascii_pkg: MAX_DIGITS (10), ASCII_ZERO (8'h30), ASCII_LF (8'h0A), the FSM state enum, and the BCD digit typedef.
REQ-030 SHALL instantiate one combinational sub-module dec_ascii_dabble_step (add-3 correction across all digits plus one-bit shift) used by CONVERT.
REQ-031 SHALL track the emit position with a digit index counter, initialised to the most significant non-zero digit (or 0 for value 0), and decremented on each handshake.

Verification
REQ-032 SHALL verify in_data=0 -> single char 0x30 with out_last=1, first out_valid 33 cycles after accept.
REQ-033 SHALL verify in_data=2971215073 (Fibonacci 47) -> "2971215073", 10 chars, out_last on the final '3'.
REQ-034 SHALL verify in_data=4294967295 -> "4294967295", and in_data=1000 -> "1000" (internal zeros kept).
REQ-035 SHALL verify random out_ready toggling during "1000" -> data stable while stalled, no dropped or duplicated chars, and in_ready=0 until the last handshake.
REQ-036 SHALL verify rst_n pulsed low after the 2nd char of "4294967295" -> out_valid=0 immediately; next value 7 emits only "7".
REQ-037 SHALL verify with DEC_ASCII_NEWLINE_EN, in_data=42 -> 0x34, 0x32, 0x0A, with out_last on 0x0A only.
